// File: rtl/spi_dac_mc_out.sv
// Multi-channel LTC2624-class SPI DAC driver: buffers one sample set per handshake and
// shifts one 24-bit command frame per channel every sample period.
module spi_dac_mc_out #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 2,
  parameter int UPDATE_ALL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                period,
  input  logic [NUM_CH*DATA_W-1:0]   samples,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       spi_sck,
  output logic                       spi_sdo,
  output logic                       spi_cs_n,
  output logic                       frame_strobe,
  output logic                       underrun,
  output logic                       busy
);

  localparam int                 SET_W    = NUM_CH * DATA_W;
  localparam int                 DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]         LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [5:0]         LAST_HALF = 6'd47;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [5:0]         half, half_nxt;     // SCK half-phase index within the 24-bit shift
  logic [2:0]         ch, ch_nxt;
  logic [23:0]        word, word_nxt;
  logic               sck_nxt, cs_n_nxt, sdo_nxt, strobe_nxt, under_nxt, busy_nxt;

  logic [15:0]        per_cnt;
  logic [SET_W-1:0]   pend, shadow;
  logic               pend_full;
  logic               fs, accept;

  assign fs       = (state == S_IDLE) && (per_cnt == '0);
  assign accept   = in_valid && !pend_full;
  assign in_ready = !pend_full;

  function automatic logic [23:0] build_word(input logic [2:0] k, input logic [SET_W-1:0] set);
    logic [15:0] data;
    logic [3:0]  cmd;
    data = '0;
    data[15 -: DATA_W] = set[int'(k)*DATA_W +: DATA_W];
    if (UPDATE_ALL != 0) cmd = (k == LAST_CH) ? 4'b0010 : 4'b0000;
    else                 cmd = 4'b0011;
    return {cmd, 1'b0, k, data};
  endfunction

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div;
    half_nxt   = half;
    ch_nxt     = ch;
    word_nxt   = word;
    sck_nxt    = spi_sck;
    cs_n_nxt   = spi_cs_n;
    sdo_nxt    = spi_sdo;
    strobe_nxt = 1'b0;
    under_nxt  = 1'b0;
    busy_nxt   = busy;

    unique case (state)
      S_IDLE: begin
        sck_nxt  = 1'b0;
        cs_n_nxt = 1'b1;
        if (fs) begin
          state_nxt = S_LOAD;
          ch_nxt    = '0;
          busy_nxt  = 1'b1;
          under_nxt = !pend_full;
        end
      end
      S_LOAD: begin
        word_nxt  = build_word(ch, shadow);
        sdo_nxt   = word_nxt[23];
        sck_nxt   = 1'b0;
        cs_n_nxt  = 1'b0;
        div_nxt   = '0;
        state_nxt = S_CS_SETUP;
      end
      S_CS_SETUP: begin
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          half_nxt  = '0;
          state_nxt = S_SHIFT;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_SHIFT: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (half == LAST_HALF) begin
            sck_nxt   = 1'b0;
            state_nxt = S_CS_HOLD;
          end else begin
            half_nxt = half + 6'd1;
            sck_nxt  = !spi_sck;
            // Data advances only when a new low phase begins.
            if (half[0]) begin
              word_nxt = {word[22:0], 1'b0};
              sdo_nxt  = word[22];
            end
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_CS_HOLD: begin
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          cs_n_nxt  = 1'b1;
          state_nxt = S_GAP;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_GAP: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (ch == LAST_CH) begin
            strobe_nxt = 1'b1;
            state_nxt  = S_DONE;
          end else begin
            ch_nxt    = ch + 3'd1;
            state_nxt = S_LOAD;
          end
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      div          <= '0;
      half         <= '0;
      ch           <= '0;
      word         <= '0;
      spi_sck      <= 1'b0;
      spi_sdo      <= 1'b0;
      spi_cs_n     <= 1'b1;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
      busy         <= 1'b0;
      per_cnt      <= '0;
      pend_full    <= 1'b0;
      pend         <= '0;
      // NOTE: the shadow set is cleared on reset because an underrun right after reset
      // retransmits it; the pending data register is reset only for determinism.
      shadow       <= '0;
    end else begin
      state        <= state_nxt;
      div          <= div_nxt;
      half         <= half_nxt;
      ch           <= ch_nxt;
      word         <= word_nxt;
      spi_sck      <= sck_nxt;
      spi_sdo      <= sdo_nxt;
      spi_cs_n     <= cs_n_nxt;
      frame_strobe <= strobe_nxt;
      underrun     <= under_nxt;
      busy         <= busy_nxt;

      if (fs)                   per_cnt <= (period == '0) ? '0 : period - 16'd1;
      else if (per_cnt != '0)   per_cnt <= per_cnt - 16'd1;

      // accept needs an empty buffer, so it never collides with the hand-off below.
      if (fs && pend_full) begin
        shadow    <= pend;
        pend_full <= 1'b0;
      end
      if (accept) begin
        pend      <= samples;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_dac_mc_out.sv
// Self-checking bench for spi_dac_mc_out: two instances (update-all on/off) share stimulus;
// a pin-level monitor decodes SPI windows and a small arithmetic model predicts the words.
module tb_spi_dac_mc_out;

  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int D   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] period = 16'd300;
  logic [23:0] samples = '0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_ready, sck, sdo, cs_n, strobe, under, busy;

  always #5 clk = ~clk;

  spi_dac_mc_out #(.NUM_CH(NCH), .DATA_W(DW), .CLK_DIV(D), .UPDATE_ALL(1)) dut0 (
    .clk(clk), .reset(reset), .period(period), .samples(samples), .in_valid(in_valid),
    .in_ready(in_ready[0]), .spi_sck(sck[0]), .spi_sdo(sdo[0]), .spi_cs_n(cs_n[0]),
    .frame_strobe(strobe[0]), .underrun(under[0]), .busy(busy[0]));

  spi_dac_mc_out #(.NUM_CH(NCH), .DATA_W(DW), .CLK_DIV(D), .UPDATE_ALL(0)) dut1 (
    .clk(clk), .reset(reset), .period(period), .samples(samples), .in_valid(in_valid),
    .in_ready(in_ready[1]), .spi_sck(sck[1]), .spi_sdo(sdo[1]), .spi_cs_n(cs_n[1]),
    .frame_strobe(strobe[1]), .underrun(under[1]), .busy(busy[1]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: DAC command word from the channel rules, by plain arithmetic.
  function automatic logic [23:0] model_word(input int ua, input int k, input logic [23:0] set);
    int cmd;
    int s;
    cmd = (ua != 0) ? ((k == NCH - 1) ? 2 : 0) : 3;
    s   = int'((set >> (DW * k)) & 24'hFFF);
    return 24'((cmd << 20) + (k << 16) + (s << 4));
  endfunction

  // ---------------- pin-level monitor ----------------
  typedef struct {
    logic [23:0] word;
    int          len;
    int          rises;
    int          off;
  } win_t;

  win_t        wq0[$];
  win_t        wq1[$];
  win_t        mon_w;
  int          cyc = 0;
  logic [1:0]  prev_sck = '0;
  logic [1:0]  prev_cs = '1;
  logic        prev_busy = 1'b0;
  logic [23:0] shreg[2];
  int          win_len[2];
  int          rises[2];
  int          first_off[2];
  int          strobe_cnt = 0;
  int          under_cnt = 0;
  int          sck_bad = 0;
  int          fs_times[$];
  int          strobe_times[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      wq0.delete();
      wq1.delete();
      prev_cs   = '1;
      prev_sck  = '0;
      prev_busy = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (!cs_n[d] && prev_cs[d]) begin
          win_len[d] = 0; rises[d] = 0; shreg[d] = '0; first_off[d] = -1;
        end
        if (!cs_n[d]) win_len[d]++;
        if (cs_n[d] && sck[d]) sck_bad++;
        if (!cs_n[d] && sck[d] && !prev_sck[d]) begin
          if (rises[d] == 0) first_off[d] = win_len[d] - 1;
          shreg[d] = {shreg[d][22:0], sdo[d]};
          rises[d]++;
        end
        if (cs_n[d] && !prev_cs[d]) begin
          mon_w = '{word: shreg[d], len: win_len[d], rises: rises[d], off: first_off[d]};
          if (d == 0) wq0.push_back(mon_w);
          else        wq1.push_back(mon_w);
        end
      end
      if (strobe[0]) begin strobe_cnt++; strobe_times.push_back(cyc); end
      if (under[0]) under_cnt++;
      if (busy[0] && !prev_busy) fs_times.push_back(cyc);
      prev_cs   = cs_n;
      prev_sck  = sck;
      prev_busy = busy[0];
    end
  end

  // ---------------- helpers ----------------
  int under_base = 0;

  task automatic wait_strobe(input string tag);
    int base;
    int i;
    base = strobe_cnt;
    i = 0;
    while (strobe_cnt == base && i < 1000) begin
      @(posedge clk); #1;
      i++;
    end
    check({tag, " strobe_seen"}, 32'(strobe_cnt != base), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [23:0] set,
                             input int exp_under, input int exp_space);
    win_t w;
    int   n;
    wait_strobe(tag);
    check({tag, " underrun_pulses"}, 32'(under_cnt - under_base), 32'(exp_under));
    under_base = under_cnt;
    for (int d = 0; d < 2; d++) begin
      n = (d == 0) ? wq0.size() : wq1.size();
      check($sformatf("%s d%0d windows", tag, d), 32'(n), 32'(NCH));
      for (int k = 0; k < NCH; k++) begin
        if (((d == 0) ? wq0.size() : wq1.size()) == 0) break;
        w = (d == 0) ? wq0.pop_front() : wq1.pop_front();
        check($sformatf("%s d%0d ch%0d word", tag, d, k), 32'(w.word),
              32'(model_word((d == 0) ? 1 : 0, k, set)));
        check($sformatf("%s d%0d ch%0d cs_low", tag, d, k), 32'(w.len), 32'(50 * D));
        check($sformatf("%s d%0d ch%0d rises", tag, d, k), 32'(w.rises), 32'd24);
        check($sformatf("%s d%0d ch%0d first_rise", tag, d, k), 32'(w.off), 32'(2 * D));
      end
    end
    if (exp_space > 0 && fs_times.size() >= 2)
      check({tag, " fs_spacing"},
            32'(fs_times[fs_times.size()-1] - fs_times[fs_times.size()-2]), 32'(exp_space));
  endtask

  // ---------------- directed sequence ----------------
  logic [23:0] set_a, set_b, set_c;
  int          base_strobe;
  int          i;

  initial begin
    set_a = {12'hABC, 12'h123};
    set_b = 24'($urandom);
    set_c = 24'($urandom);

    repeat (4) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst d%0d sck", d), 32'(sck[d]), 32'd0);
      check($sformatf("rst d%0d sdo", d), 32'(sdo[d]), 32'd0);
      check($sformatf("rst d%0d cs_n", d), 32'(cs_n[d]), 32'd1);
      check($sformatf("rst d%0d strobe", d), 32'(strobe[d]), 32'd0);
      check($sformatf("rst d%0d underrun", d), 32'(under[d]), 32'd0);
      check($sformatf("rst d%0d busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("rst d%0d in_ready", d), 32'(in_ready[d]), 32'd1);
    end

    // Frame start and accept coincide with an empty buffer: underrun, data held.
    samples  = set_a;
    in_valid = 1'b1;
    reset    = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("fs0 in_ready", 32'(in_ready[0]), 32'd0);
    check("fs0 underrun", 32'(under[0]), 32'd1);
    check("fs0 busy", 32'(busy[0]), 32'd1);

    check_frame("f0", 24'h0, 1, 0);
    check_frame("f1", set_a, 0, 300);
    check_frame("f2", set_a, 1, 300);

    // Back-to-back sets with in_valid held.
    samples  = set_b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("b accepted", 32'(in_ready[0]), 32'd0);
    samples = set_c;
    i = 0;
    while (!in_ready[0] && i < 1000) begin
      @(posedge clk); #1;
      i++;
    end
    check("ready returns", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    check("c accepted", 32'(in_ready[0]), 32'd0);
    in_valid = 1'b0;
    period   = 16'd50;

    check_frame("f3", set_b, 0, 300);
    check_frame("f4", set_c, 0, 300);
    check_frame("f5", set_c, 1, 208);
    check_frame("f6", set_c, 1, 208);
    if (strobe_times.size() >= 2)
      check("strobe spacing",
            32'(strobe_times[strobe_times.size()-1] - strobe_times[strobe_times.size()-2]),
            32'd208);

    // Reset during bit 10 of channel 0.
    i = 0;
    while (!(wq0.size() == 0 && !cs_n[0] && rises[0] == 10) && i < 1000) begin
      @(posedge clk); #1;
      i++;
    end
    check("reached bit10", 32'(rises[0]), 32'd10);
    base_strobe = strobe_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort d%0d cs_n", d), 32'(cs_n[d]), 32'd1);
      check($sformatf("abort d%0d sck", d), 32'(sck[d]), 32'd0);
      check($sformatf("abort d%0d sdo", d), 32'(sdo[d]), 32'd0);
      check($sformatf("abort d%0d in_ready", d), 32'(in_ready[d]), 32'd1);
      check($sformatf("abort d%0d busy", d), 32'(busy[d]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("abort no strobe", 32'(strobe_cnt), 32'(base_strobe));
    reset = 1'b0;
    under_base = under_cnt;
    check("post-reset idle busy", 32'(busy[0]), 32'd0);
    check_frame("f8", 24'h0, 1, 0);

    check("sck idle while cs high", 32'(sck_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_dac_mc_out.md
Name: spi_dac_mc_out

Overview:
Multi-channel SPI DAC driver, a parametrised successor to the single-channel Spartan-3E DAC writer. It accepts one sample set for all channels over a valid/ready handshake and buffers it. Each sample period it shifts one 24-bit command frame per channel to an LTC2624-class DAC. The sample rate is programmable, the SCK divider is set by parameter, and optional "update-all on last channel" mode gives simultaneous channel output. It sits between the synth voice mixer and the board DAC pins.

Parameters:
NUM_CH, 4, number of DAC channels (1..8); the channel index is the 4-bit DAC address.
DATA_W, 12, sample width per channel (1..16); left-justified into a 16-bit field, zero-padded.
CLK_DIV, 2, SCK half-period in clk cycles (D, >=1).
UPDATE_ALL, 1, 1: channels 0..N-2 use cmd 4'b0000 (write input reg) and the last channel uses 4'b0010 (write, update all); 0: every channel uses 4'b0011 (write and update).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high
period  input  16  sample period in clk cycles; 0 means back-to-back
samples  input  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W]
in_valid  input  1  sample set valid
in_ready  output  1  pending buffer empty
spi_sck  output  1  SPI clock, idle low
spi_sdo  output  1  SPI data, MSB first
spi_cs_n  output  1  DAC chip select, active low
frame_strobe  output  1  one-cycle pulse after the last channel completes
underrun  output  1  one-cycle pulse when a frame starts with no new sample
busy  output  1  high from frame start to frame_strobe inclusive

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is clk.
- Reset values: spi_sck=0, spi_sdo=0, spi_cs_n=1, frame_strobe=0, underrun=0, busy=0, in_ready=1.
- Reset also forces: FSM to IDLE, pending buffer empty, shadow register all-zero, period counter=0.
- Reset mid-frame aborts immediately with the outputs above. No frame_strobe is issued.
- Input buffer: one-entry pending buffer. On in_valid&&in_ready, samples are latched and in_ready is 0 from the next cycle.
- Frame start (FS): occurs when the state is IDLE and the period counter is 0. At FS:
  - the counter loads period-1 (0 if period is 0);
  - if the pending buffer is full, it is copied to the shadow register, emptied, and in_ready=1 from the next cycle;
  - otherwise the shadow register is kept and underrun pulses.
- Same-cycle accept and FS with an empty buffer: underrun pulses, and the accepted data is held for the next frame.
- Period counter: decrements each cycle while nonzero, independent of FSM state.
- Frame spacing: max(period, NUM_CH*(51*D+1)+2) cycles.
- FSM states, per channel k = 0..NUM_CH-1:
  - LOAD (1 clk): build word = {cmd_k, 4'(k), sample_k, zero pad}, 24 bits.
  - CS_SETUP (D clk): cs_n=0, sck=0, sdo=word[23].
  - SHIFT (24 bits x 2D clk): each bit is sck low for D cycles, then high for D cycles. sdo changes only at the start of the low phase. The DAC samples on the rising edge.
  - CS_HOLD (D clk): sck=0, cs_n=0.
  - GAP (D clk): cs_n=1. Then go to LOAD for k+1, or to DONE after the last channel.
  - DONE (1 clk): frame_strobe=1, then IDLE.
- Per-channel timing:
  - cs_n is low for exactly 50*D cycles.
  - First sck rise is 2*D cycles after cs_n falls.
  - Exactly 24 rising edges occur per cs_n low window.
- All SPI outputs are registered. sck never toggles while cs_n=1.
- Period change: a new period value takes effect at the next FS.

Test Plan:
1. NUM_CH=2, DATA_W=12, D=2, UPDATE_ALL=1, period=300; send ch0=12'h123, ch1=12'hABC -> words 24'h001230 then 24'h21ABC0 captured on sck rises, 24 rises per cs_n window, cs_n low for 100 clk, one frame_strobe, no underrun.
2. Same setup with UPDATE_ALL=0 -> words 24'h301230 and 24'h31ABC0.
3. No new sample after test 1 -> next FS 300 clk later, underrun pulses once, identical words resent.
4. Two sets back-to-back with in_valid held -> first accepted at once, in_ready=0 until the next FS, second accepted the cycle after in_ready returns to 1, both transmitted in order.
5. period=50 -> FS spacing measured at 208 clk, frame_strobe every 208 clk.
6. Assert reset during bit 10 of ch0 -> next cycle cs_n=1, sck=0, sdo=0, in_ready=1, busy=0, no frame_strobe; after release, idle until a new FS.
